stage_seq_monitor: RTL and testbench

// - Passive checker and retire counter on the stage-controller write-enable strobes of the multi-cycle core.
// - Tracks the expected strobe order and counts retired instructions.
// - Flags protocol violations: out-of-order, multi-hot, stall timeout, stray pc_wren.
// - Sits beside the stage controller; its outputs feed debug LEDs and UART status.

---
 rtl/stage_mon_pkg.sv | 34 +++
 rtl/stage_seq_monitor_decode.sv | 30 +++
 rtl/stage_seq_monitor.sv | 177 +++++++++++++++++
 tb/tb_stage_seq_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_mon_pkg.sv
// stage_mon_pkg: shared types for the stage-strobe monitor.
//   phase_t      - controller phases, encoded in strobe order (P_IF_ID=0 .. P_WB_IF=6)
//   err_t        - error codes reported on err_code
//   next_phase() - successor phase; P_WB_IF wraps back to P_IF_ID
package stage_mon_pkg;

  localparam int NUM_PHASES = 7;

  typedef enum logic [2:0] {
    P_IF_ID  = 3'd0,
    P_ID_EX  = 3'd1,
    P_EX_MEM = 3'd2,
    P_MEM    = 3'd3,
    P_MEM_WB = 3'd4,
    P_WB     = 3'd5,
    P_WB_IF  = 3'd6
  } phase_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ORDER   = 3'd1,
    ERR_MULTI   = 3'd2,
    ERR_PC      = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_t;

  function automatic phase_t next_phase(input phase_t p);
    if (p == P_WB_IF) begin
      return P_IF_ID;
    end
    return phase_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/stage_seq_monitor_decode.sv
// stage_strobe_decode: combinational decode of the seven write-enable strobes.
//   strobes_i [7] - bit i is the strobe of phase i (if_id at bit 0 .. wb_if at bit 6)
//   phase_o       - phase of the set strobe (meaningful only when valid_o=1)
//   valid_o       - exactly one strobe set
//   multi_o       - more than one strobe set
module stage_strobe_decode
  import stage_mon_pkg::*;
(
  input  logic [NUM_PHASES-1:0] strobes_i,
  output phase_t                phase_o,
  output logic                  valid_o,
  output logic                  multi_o
);

  logic [2:0] ones;

  always_comb begin
    ones    = 3'd0;
    phase_o = P_IF_ID;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (strobes_i[i]) begin
        ones    = ones + 3'd1;
        phase_o = phase_t'(3'(i));
      end
    end
    valid_o = (ones == 3'd1);
    multi_o = (ones > 3'd1);
  end

endmodule

// File: rtl/stage_seq_monitor.sv
// stage_seq_monitor: passive checker and retire counter for the stage-controller
// write-enable strobes of the multi-cycle core.
// Ports:
//   clk, reset_n (sync, active-low), stage_reset_n (0 = controller in INIT)
//   if_id_wren .. wb_if_wren - phase strobes, pc_wren - legal only with wb_if_wren
//   err_clr       - clears the sticky error (a same-cycle new error wins)
//   instr_count   - retired instructions (wraps)
//   expect_phase  - next expected phase (phase_t encoding)
//   err, err_code - sticky error flag and first error code since last clear
// Optional build macro STAGE_MON_CYCLE_CNT_EN adds:
//   cycle_count   - cycles spent with stage_reset_n=1
//   last_cpi      - cycles between the last two retires, saturating at 255
module stage_seq_monitor
  import stage_mon_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int MAX_GAP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stage_reset_n,
  input  logic             if_id_wren,
  input  logic             id_ex_wren,
  input  logic             ex_mem_wren,
  input  logic             ram_wren,
  input  logic             mem_wb_wren,
  input  logic             reg_wren,
  input  logic             wb_if_wren,
  input  logic             pc_wren,
  input  logic             err_clr,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       expect_phase,
  output logic             err,
  output logic [2:0]       err_code
`ifdef STAGE_MON_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       last_cpi
`endif
);

  localparam int GAP_W = $clog2(MAX_GAP + 1);

  logic [NUM_PHASES-1:0] strobes;
  phase_t                dec_phase;
  logic                  dec_valid;
  logic                  dec_multi;

  phase_t                expect_q, expect_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;
  err_t                  code_q, code_d;
  err_t                  new_code;
  logic                  retire;
  logic                  timeout;

  assign strobes = {wb_if_wren, reg_wren, mem_wb_wren, ram_wren,
                    ex_mem_wren, id_ex_wren, if_id_wren};

  stage_strobe_decode u_decode (
    .strobes_i (strobes),
    .phase_o   (dec_phase),
    .valid_o   (dec_valid),
    .multi_o   (dec_multi)
  );

  always_comb begin
    expect_d = expect_q;
    gap_d    = gap_q;
    count_d  = count_q;
    err_d    = err_q;
    code_d   = code_q;
    new_code = ERR_NONE;
    retire   = 1'b0;
    timeout  = 1'b0;

    if (!stage_reset_n) begin
      // Controller in INIT: everything it does is ignored.
      expect_d = P_IF_ID;
      gap_d    = '0;
    end else begin
      if (dec_multi) begin
        gap_d = '0;
      end else if (dec_valid) begin
        gap_d = '0;
        // Resync to the observed phase even when it was out of order.
        expect_d = next_phase(dec_phase);
        retire   = (dec_phase == P_WB_IF);
      end else if (gap_q == GAP_W'(MAX_GAP - 1)) begin
        // This idle cycle is the MAX_GAP-th in a row.
        gap_d   = '0;
        timeout = 1'b1;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end

      // Priority among simultaneous errors: MULTI > ORDER > PC > TIMEOUT.
      if (dec_multi) begin
        new_code = ERR_MULTI;
      end else if (dec_valid && (dec_phase != expect_q)) begin
        new_code = ERR_ORDER;
      end else if (pc_wren && !wb_if_wren) begin
        new_code = ERR_PC;
      end else if (timeout) begin
        new_code = ERR_TIMEOUT;
      end
    end

    if (retire) begin
      count_d = count_q + CNT_W'(1);
    end

    if (err_clr) begin
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end
    if (new_code != ERR_NONE) begin
      err_d = 1'b1;
      // First error since the last clear keeps its code.
      if (!err_q || err_clr) begin
        code_d = new_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      expect_q <= P_IF_ID;
      gap_q    <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      expect_q <= expect_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign instr_count  = count_q;
  assign expect_phase = expect_q;
  assign err          = err_q;
  assign err_code     = code_q;

`ifdef STAGE_MON_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [7:0]       since_q;
  logic [7:0]       cpi_q;

  // since_q counts non-retire running cycles after the last retire, so the
  // interval reported at the next retire is since_q + 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_q <= '0;
      since_q <= '0;
      cpi_q   <= '0;
    end else if (stage_reset_n) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) begin
        cpi_q   <= (since_q == 8'hFF) ? 8'hFF : since_q + 8'd1;
        since_q <= '0;
      end else if (since_q != 8'hFF) begin
        since_q <= since_q + 8'd1;
      end
    end
  end

  assign cycle_count = cycle_q;
  assign last_cpi    = cpi_q;
`else
  // No profiling counters in this build.
`endif

endmodule

// File: tb/tb_stage_seq_monitor.sv
module tb_stage_seq_monitor;

  localparam logic [6:0] NO     = 7'h00;
  localparam logic [6:0] S_IF   = 7'h01;
  localparam logic [6:0] S_ID   = 7'h02;
  localparam logic [6:0] S_EX   = 7'h04;
  localparam logic [6:0] S_RAM  = 7'h08;
  localparam logic [6:0] S_MWB  = 7'h10;
  localparam logic [6:0] S_REG  = 7'h20;
  localparam logic [6:0] S_WBIF = 7'h40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stage_reset_n = 1'b1;
  logic [6:0]  stb = '0;
  logic        pc_wren = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] instr_count;
  logic [2:0]  expect_phase;
  logic        err;
  logic [2:0]  err_code;
`ifdef STAGE_MON_CYCLE_CNT_EN
  logic [31:0] cycle_count;
  logic [7:0]  last_cpi;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stage_seq_monitor #(.CNT_W(32), .MAX_GAP(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stage_reset_n (stage_reset_n),
    .if_id_wren    (stb[0]),
    .id_ex_wren    (stb[1]),
    .ex_mem_wren   (stb[2]),
    .ram_wren      (stb[3]),
    .mem_wb_wren   (stb[4]),
    .reg_wren      (stb[5]),
    .wb_if_wren    (stb[6]),
    .pc_wren       (pc_wren),
    .err_clr       (err_clr),
    .instr_count   (instr_count),
    .expect_phase  (expect_phase),
    .err           (err),
    .err_code      (err_code)
`ifdef STAGE_MON_CYCLE_CNT_EN
    ,
    .cycle_count   (cycle_count),
    .last_cpi      (last_cpi)
`endif
  );

  typedef struct {
    logic [6:0]  stb;
    logic        pc;
    logic        clr;
    logic        srn;
    logic [31:0] cnt;
    logic [2:0]  ph;
    logic        e;
    logic [2:0]  code;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [6:0] s, input logic pc, input logic clr, input logic srn,
                     input int cnt, input int ph, input logic e, input int code);
    vec_t v;
    v.stb = s; v.pc = pc; v.clr = clr; v.srn = srn;
    v.cnt = cnt; v.ph = 3'(ph); v.e = e; v.code = 3'(code);
    tbl.push_back(v);
  endtask

  // One instruction of the 9-cycle controller: 7 strobes plus two wait cycles.
  task automatic nom(input int c, input logic e, input int code);
    add(S_IF,   0, 0, 1, c,     1, e, code);
    add(S_ID,   0, 0, 1, c,     2, e, code);
    add(S_EX,   0, 0, 1, c,     3, e, code);
    add(NO,     0, 0, 1, c,     3, e, code);
    add(S_RAM,  0, 0, 1, c,     4, e, code);
    add(S_MWB,  0, 0, 1, c,     5, e, code);
    add(NO,     0, 0, 1, c,     5, e, code);
    add(S_REG,  0, 0, 1, c,     6, e, code);
    add(S_WBIF, 1, 0, 1, c + 1, 0, e, code);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_count"}, instr_count, 32'd0);
    check({tag, "_phase"}, 32'(expect_phase), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
`ifdef STAGE_MON_CYCLE_CNT_EN
    check({tag, "_cycles"}, cycle_count, 32'd0);
    check({tag, "_cpi"}, 32'(last_cpi), 32'd0);
`endif
  endtask

  initial begin
    int a_end;

    // Nominal loop, 3 instructions.
    nom(0, 0, 0);
    nom(1, 0, 0);
    nom(2, 0, 0);
    a_end = tbl.size();

    // Skip P_MEM: ORDER error, resync to P_WB; the loop continues with the code held.
    add(S_IF,   0, 0, 1, 3, 1, 0, 0);
    add(S_ID,   0, 0, 1, 3, 2, 0, 0);
    add(S_EX,   0, 0, 1, 3, 3, 0, 0);
    add(NO,     0, 0, 1, 3, 3, 0, 0);
    add(S_MWB,  0, 0, 1, 3, 5, 1, 1);
    add(NO,     0, 0, 1, 3, 5, 1, 1);
    add(S_REG,  0, 0, 1, 3, 6, 1, 1);
    add(S_WBIF, 1, 0, 1, 4, 0, 1, 1);
    nom(4, 1, 1);
    add(NO,     0, 1, 1, 5, 0, 0, 0);

    // ram+reg together: MULTI, phase and count held; then clear and finish.
    add(S_IF,          0, 0, 1, 5, 1, 0, 0);
    add(S_ID,          0, 0, 1, 5, 2, 0, 0);
    add(S_EX,          0, 0, 1, 5, 3, 0, 0);
    add(S_RAM | S_REG, 0, 0, 1, 5, 3, 1, 2);
    add(NO,            0, 1, 1, 5, 3, 0, 0);
    add(S_RAM,         0, 0, 1, 5, 4, 0, 0);
    add(S_MWB,         0, 0, 1, 5, 5, 0, 0);
    add(NO,            0, 0, 1, 5, 5, 0, 0);
    add(S_REG,         0, 0, 1, 5, 6, 0, 0);
    add(S_WBIF,        1, 0, 1, 6, 0, 0, 0);

    // Stall after id_ex: timeout on the 4th idle cycle, phase stays P_EX_MEM.
    add(S_IF,   0, 0, 1, 6, 1, 0, 0);
    add(S_ID,   0, 0, 1, 6, 2, 0, 0);
    add(NO,     0, 0, 1, 6, 2, 0, 0);
    add(NO,     0, 0, 1, 6, 2, 0, 0);
    add(NO,     0, 0, 1, 6, 2, 0, 0);
    add(NO,     0, 0, 1, 6, 2, 1, 4);
    add(S_EX,   0, 1, 1, 6, 3, 0, 0);
    add(S_RAM,  0, 0, 1, 6, 4, 0, 0);
    add(S_MWB,  0, 0, 1, 6, 5, 0, 0);
    add(S_REG,  0, 0, 1, 6, 6, 0, 0);
    add(S_WBIF, 1, 0, 1, 7, 0, 0, 0);

    // Stray pc_wren: PC error; a later ORDER keeps code 3; clear + MULTI gives code 2.
    add(NO,          1, 0, 1, 7, 0, 1, 3);
    add(S_ID,        0, 0, 1, 7, 2, 1, 3);
    add(S_IF | S_ID, 0, 1, 1, 7, 2, 1, 2);
    add(NO,          0, 1, 1, 7, 2, 0, 0);
    add(S_EX,        0, 0, 1, 7, 3, 0, 0);
    add(S_RAM,       0, 0, 1, 7, 4, 0, 0);
    add(S_MWB,       0, 0, 1, 7, 5, 0, 0);
    add(S_REG,       0, 0, 1, 7, 6, 0, 0);
    add(S_WBIF,      1, 0, 1, 8, 0, 0, 0);

    // Stage reset at P_MEM_WB: strobes and pc ignored, no timeout, count held.
    add(S_IF,  0, 0, 1, 8, 1, 0, 0);
    add(S_ID,  0, 0, 1, 8, 2, 0, 0);
    add(S_EX,  0, 0, 1, 8, 3, 0, 0);
    add(S_RAM, 0, 0, 1, 8, 4, 0, 0);
    add(S_MWB, 0, 0, 1, 8, 5, 0, 0);
    add(S_REG, 1, 0, 0, 8, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(NO, 0, 0, 0, 8, 0, 0, 0);
    nom(8, 0, 0);

    // Reset state.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");

    reset_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      stb           = tbl[i].stb;
      pc_wren       = tbl[i].pc;
      err_clr       = tbl[i].clr;
      stage_reset_n = tbl[i].srn;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i), instr_count, tbl[i].cnt);
      check($sformatf("v%0d_phase", i), 32'(expect_phase), 32'(tbl[i].ph));
      check($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].e));
      check($sformatf("v%0d_code", i), 32'(err_code), 32'(tbl[i].code));
      $display("vec %0d: stb=%b pc=%b clr=%b srn=%b -> count=%0d phase=%0d err=%b code=%0d",
               i, tbl[i].stb, tbl[i].pc, tbl[i].clr, tbl[i].srn,
               instr_count, expect_phase, err, err_code);
`ifdef STAGE_MON_CYCLE_CNT_EN
      if (i == a_end - 1) begin
        check("nominal_cpi", 32'(last_cpi), 32'd9);
        check("nominal_cycles", cycle_count, 32'd27);
      end
`endif
    end

    // Full reset after activity.
    stb = NO; pc_wren = 1'b0; err_clr = 1'b0; stage_reset_n = 1'b1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset("final_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
